// File: rtl/karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl
// Sequential 8x8 unsigned Karatsuba multiplier built around a single shared
// 5x5 multiplier. The three partial products A = X1*Y1, C = X0*Y0 and
// S = (X1+X0)*(Y1+Y0) are computed on consecutive cycles. The middle factor
// B = S - A - C and the product P = (A<<8) + (B<<4) + C are then formed in a
// final combine cycle.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request, sampled only while idle
//   X      in   8   multiplicand (X1 = X[7:4], X0 = X[3:0])
//   Y      in   8   multiplier   (Y1 = Y[7:4], Y0 = Y[3:0])
//   busy   out  1   high from start acceptance until done is raised
//   done   out  1   one-cycle pulse, B/P valid from here on
//   B      out  10  middle factor X1*Y0 + X0*Y1
//   P      out  16  product X*Y
// ---------------------------------------------------------------------------
module karatsuba_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  X,
   input  logic [7:0]  Y,
   output logic        busy,
   output logic        done,
   output logic [9:0]  B,
   output logic [15:0] P
);

   localparam int unsigned OP_W   = 8;   // operand width
   localparam int unsigned HALF_W = 4;   // operand half width
   localparam int unsigned FAC_W  = 5;   // multiplier input width (half + carry)
   localparam int unsigned MUL_W  = 10;  // multiplier output width
   localparam int unsigned AC_W   = 8;   // A and C partial product width
   localparam int unsigned B_W    = 10;  // middle factor width
   localparam int unsigned P_W    = 16;  // product width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL_A,
      ST_MUL_C,
      ST_MUL_S,
      ST_COMBINE
   } state_t;

   state_t state, state_next;

   logic [OP_W-1:0]  x_q, y_q;
   logic [AC_W-1:0]  a_q, c_q;
   logic [MUL_W-1:0] s_q;

   logic load_op, load_a, load_c, load_s, load_res;
   logic busy_next, done_next;

   logic [FAC_W-1:0] mul_in_a, mul_in_b;
   logic [MUL_W-1:0] mul_out;
   logic [FAC_W-1:0] x_sum, y_sum;
   logic [B_W-1:0]   b_val;
   logic [P_W-1:0]   p_val;

   // Half sums carry into the fifth bit (max 15+15 = 30)
   assign x_sum = FAC_W'(x_q[OP_W-1:HALF_W]) + FAC_W'(x_q[HALF_W-1:0]);
   assign y_sum = FAC_W'(y_q[OP_W-1:HALF_W]) + FAC_W'(y_q[HALF_W-1:0]);

   // Shared multiplier operand mux, selected by state
   always_comb begin
      mul_in_a = '0;
      mul_in_b = '0;
      unique case (state)
         ST_MUL_A: begin
            mul_in_a = FAC_W'(x_q[OP_W-1:HALF_W]);
            mul_in_b = FAC_W'(y_q[OP_W-1:HALF_W]);
         end
         ST_MUL_C: begin
            mul_in_a = FAC_W'(x_q[HALF_W-1:0]);
            mul_in_b = FAC_W'(y_q[HALF_W-1:0]);
         end
         ST_MUL_S: begin
            mul_in_a = x_sum;
            mul_in_b = y_sum;
         end
         default: ;
      endcase
   end

   assign mul_out = MUL_W'(mul_in_a) * MUL_W'(mul_in_b);

   // S >= A + C always holds, so the subtraction cannot wrap
   assign b_val = s_q - B_W'(a_q) - B_W'(c_q);
   assign p_val = (P_W'(a_q) << 8) + (P_W'(b_val) << 4) + P_W'(c_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state, datapath enables and next output values
   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      load_a     = 1'b0;
      load_c     = 1'b0;
      load_s     = 1'b0;
      load_res   = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               load_op    = 1'b1;
               busy_next  = 1'b1;
               state_next = ST_MUL_A;
            end
         end
         ST_MUL_A: begin
            load_a     = 1'b1;
            busy_next  = 1'b1;
            state_next = ST_MUL_C;
         end
         ST_MUL_C: begin
            load_c     = 1'b1;
            busy_next  = 1'b1;
            state_next = ST_MUL_S;
         end
         ST_MUL_S: begin
            load_s     = 1'b1;
            busy_next  = 1'b1;
            state_next = ST_COMBINE;
         end
         ST_COMBINE: begin
            load_res   = 1'b1;
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand and partial product registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
         a_q <= '0;
         c_q <= '0;
         s_q <= '0;
      end else begin
         if (load_op) begin
            x_q <= X;
            y_q <= Y;
         end
         if (load_a) a_q <= mul_out[AC_W-1:0];
         if (load_c) c_q <= mul_out[AC_W-1:0];
         if (load_s) s_q <= mul_out;
      end
   end

   // Registered outputs; B and P hold until the next combine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         B    <= '0;
         P    <= '0;
      end else begin
         busy <= busy_next;
         done <= done_next;
         if (load_res) begin
            B <= b_val;
            P <= p_val;
         end
      end
   end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_seq_ctrl
// Self-checking bench: expected {B,P} pushed to a queue at start, popped and
// compared when done pulses. Reference is plain X*Y and X1*Y0 + X0*Y1.
// ---------------------------------------------------------------------------
module tb_karatsuba_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  X;
   logic [7:0]  Y;
   logic        busy;
   logic        done;
   logic [9:0]  B;
   logic [15:0] P;

   typedef struct {
      logic [9:0]  b;
      logic [15:0] p;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_start  = 0;
   int          n_done   = 0;
   logic [15:0] p_hold   = '0;

   karatsuba_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .X     (X),
      .Y     (Y),
      .busy  (busy),
      .done  (done),
      .B     (B),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      logic [7:0] x1, x0, y1, y0;
      x1 = {4'd0, x[7:4]};
      x0 = {4'd0, x[3:0]};
      y1 = {4'd0, y[7:4]};
      y0 = {4'd0, y[3:0]};
      e.p = 16'(x) * 16'(y);
      e.b = 10'(x1 * y0) + 10'(x0 * y1);
      return e;
   endfunction

   // Output monitor: scoreboard pop on done, P must hold otherwise
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_hold = '0;
      end else if (done) begin
         exp_t e;
         n_done++;
         if (exp_q.size() == 0) begin
            check_eq("done_unexpected", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("B", 32'(B), 32'(e.b));
            check_eq("P", 32'(P), 32'(e.p));
         end
         p_hold = P;
      end else begin
         check_eq("P_hold", 32'(P), 32'(p_hold));
      end
   end

   // Called at a negedge; returns at the negedge where done is high
   task automatic run_op(input logic [7:0] x, input logic [7:0] y);
      X     = x;
      Y     = y;
      start = 1'b1;
      exp_q.push_back(model(x, y));
      n_start++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         X     = 8'($urandom);
         Y     = 8'($urandom);
         check_eq("busy_run", 32'(busy), 32'd1);
         check_eq("done_run", 32'(done), 32'd0);
      end
      @(negedge clk);
      check_eq("busy_at_done", 32'(busy), 32'd0);
      check_eq("done_at_k4", 32'(done), 32'd1);
   endtask

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] hx, hy;
      int         done_snap;
      rst_n = 1'b1;
      start = 1'b0;
      X     = '0;
      Y     = '0;
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_B", 32'(B), 32'd0);
      check_eq("rst_P", 32'(P), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases, the last two back-to-back
      run_op(8'h60, 8'h00);
      @(negedge clk);
      check_eq("done_low_k5", 32'(done), 32'd0);
      run_op(8'hE5, 8'h41);
      @(negedge clk);
      run_op(8'h20, 8'h40);
      run_op(8'hFF, 8'hFF);
      @(negedge clk);

      // start held high, operands toggled each cycle: accepted every 5 cycles
      for (int n = 0; n < 15; n++) begin
         hx    = 8'($urandom);
         hy    = 8'($urandom);
         X     = hx;
         Y     = hy;
         start = 1'b1;
         if (n % 5 == 0) begin
            exp_q.push_back(model(hx, hy));
            n_start++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (6) @(negedge clk);

      // Async reset during MUL_S discards the operation
      X     = 8'hE5;
      Y     = 8'h41;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      check_eq("midrst_B", 32'(B), 32'd0);
      check_eq("midrst_P", 32'(P), 32'd0);
      #1 rst_n = 1'b1;
      done_snap = n_done;
      repeat (8) @(negedge clk);
      check_eq("no_done_after_rst", 32'(n_done), 32'(done_snap));
      run_op(8'hE5, 8'h41);
      @(negedge clk);

      // Corners and random sweep, back-to-back
      run_op(8'h00, 8'h00);
      run_op(8'hFF, 8'h00);
      run_op(8'h0F, 8'hF0);
      run_op(8'hF0, 8'h0F);
      run_op(8'h01, 8'hFF);
      for (int i = 0; i < 3000; i++) begin
         run_op(8'($urandom), 8'($urandom));
      end
      repeat (8) @(negedge clk);

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      check_eq("done_count", 32'(n_done), 32'(n_start));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
